mem_arbiter: RTL

//  Shares one pipelined multi-cycle memory between the instruction-side
//  (I) and data-side (D) requesters of the CPU.
//  - Reads are cache-block fills of BURST_LEN words; writes are single words.
//  - Sits between the cache/fetch logic and the unified main memory.
//  - Sequences each transaction: address issue, latency tracking, word return, completion.

---
 rtl/wisc_mem_pkg.sv | 16 +
 rtl/mem_lat_tracker.sv | 44 ++++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/wisc_mem_pkg.sv
// Shared encodings and defaults for the I/D memory arbiter.
package wisc_mem_pkg;

    localparam int BURST_LEN_DEF = 8;
    localparam int LAT_DEF       = 4;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Requester side encoding
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

endpackage

// File: rtl/mem_lat_tracker.sv
// LAT-deep delay line carrying {valid, word index} for every memory issue.
// The head of the line lines up with the cycle the memory returns data.
module mem_lat_tracker #(
    parameter int LAT    = 4,
    parameter int WORD_W = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_vld,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_vld,
    output logic [WORD_W-1:0] out_word
);

    logic [LAT-1:0]             vld_q, vld_d;
    logic [LAT-1:0][WORD_W-1:0] word_q, word_d;

    // Shift every stage one step toward the head each cycle
    always_comb begin
        vld_d     = vld_q;
        word_d    = word_q;
        vld_d[0]  = in_vld;
        word_d[0] = in_word;
        for (int s = 1; s < LAT; s++) begin
            vld_d[s]  = vld_q[s-1];
            word_d[s] = word_q[s-1];
        end
    end

    // Clear drops everything in flight so no stale return survives a reset
    always_ff @(posedge clk) begin
        if (clr) begin
            vld_q  <= '0;
            word_q <= '0;
        end else begin
            vld_q  <= vld_d;
            word_q <= word_d;
        end
    end

    assign out_vld  = vld_q[LAT-1];
    assign out_word = word_q[LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one pipelined memory between the I-fetch and D-cache requesters.
// One transaction at a time: block-read bursts or single-word writes.
module mem_arbiter
    import wisc_mem_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int LAT       = LAT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_req,
    input  logic [ADDR_W-1:0]            i_addr,
    output logic                         i_rvalid,
    output logic [$clog2(BURST_LEN)-1:0] i_rword,
    output logic                         i_done,
    input  logic                         d_req,
    input  logic                         d_wr,
    input  logic [ADDR_W-1:0]            d_addr,
    input  logic [DATA_W-1:0]            d_wdata,
    output logic                         d_rvalid,
    output logic [$clog2(BURST_LEN)-1:0] d_rword,
    output logic                         d_done,
    output logic [DATA_W-1:0]            rdata,
    output logic                         mem_en,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata
);

    localparam int                WORD_W    = $clog2(BURST_LEN);
    localparam logic [ADDR_W-1:0] BLK_MASK  = ADDR_W'(2 * BURST_LEN - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BURST_LEN - 1);

    logic [1:0]        state_q, state_d;
    logic              side_q, side_d;
    logic              last_q, last_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;

    logic              grant_i, grant_d;
    logic              issue;
    logic              trk_vld;
    logic [WORD_W-1:0] trk_word;
    logic              done;
    logic              rvalid;

    // Round-robin: on a tie the side that did not win last time goes next
    always_comb begin
        grant_i = i_req && (!d_req || last_q == SIDE_D);
        grant_d = d_req && !grant_i;
    end

    // Completion is the head of the latency line for a write, or the last
    // word of a burst; the request lines play no part once granted
    always_comb begin
        issue  = (state_q == ST_ISSUE);
        rvalid = trk_vld && !wr_q;
        done   = trk_vld && (wr_q || trk_word == LAST_WORD);
    end

    // FSM, grant latch and issue counter
    always_comb begin
        state_d = state_q;
        side_d  = side_q;
        last_d  = last_q;
        wr_d    = wr_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (grant_i) begin
                    side_d  = SIDE_I;
                    last_d  = SIDE_I;
                    wr_d    = 1'b0;
                    base_d  = i_addr & ~BLK_MASK;
                    wdata_d = '0;
                    state_d = ST_ISSUE;
                end else if (grant_d) begin
                    side_d  = SIDE_D;
                    last_d  = SIDE_D;
                    wr_d    = d_wr;
                    base_d  = d_wr ? (d_addr & ~ADDR_W'(1)) : (d_addr & ~BLK_MASK);
                    wdata_d = d_wdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wr_q || cnt_q == LAST_WORD) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + WORD_W'(1);
                end
            end
            ST_DRAIN: begin
                if (done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            side_q  <= SIDE_I;
            last_q  <= SIDE_I;
            wr_q    <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            side_q  <= side_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Writes also enter the line so their completion lands LAT cycles later
    mem_lat_tracker #(
        .LAT    (LAT),
        .WORD_W (WORD_W)
    ) u_trk (
        .clk      (clk),
        .clr      (rst),
        .in_vld   (issue),
        .in_word  (cnt_q),
        .out_vld  (trk_vld),
        .out_word (trk_word)
    );

    // Outputs are gated to zero when not qualified so idle/reset reads as 0
    always_comb begin
        mem_en    = issue;
        mem_wr    = issue && wr_q;
        mem_addr  = issue ? (base_q | (ADDR_W'(cnt_q) << 1)) : '0;
        mem_wdata = (issue && wr_q) ? wdata_q : '0;
        i_rvalid  = rvalid && side_q == SIDE_I;
        d_rvalid  = rvalid && side_q == SIDE_D;
        i_rword   = i_rvalid ? trk_word : '0;
        d_rword   = d_rvalid ? trk_word : '0;
        rdata     = rvalid ? mem_rdata : '0;
        i_done    = done && side_q == SIDE_I;
        d_done    = done && side_q == SIDE_D;
    end

endmodule
